fsk_modulator: RTL
==================

FSK_MODULATOR -- requirements
Module: fsk_modulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the number of bits per accepted word, sent MSB first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, DATA_W bits: the word to transmit.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-006 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-007 The block SHALL have port dout, output, 1 bit: the registered FSK square-wave line output.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a word is held or being sent.
REQ-009 The block SHALL have port bit_start, output, 1 bit: one-cycle pulse in the first cycle of each bit period.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after a word's last bit period ends.

Function
REQ-011 The block SHALL hold accepted words in a 1-entry holding register (hold, hold_full) feeding a DATA_W-bit shift register.
REQ-012 The block SHALL drive din_ready = !hold_full && !rst, combinationally.
REQ-013 A handshake SHALL occur on a rising edge where din_valid && din_ready; at that edge hold <= din and hold_full <= 1.
REQ-014 The block SHALL have FSM states IDLE and SEND.
REQ-015 IDLE -> SEND SHALL occur on the edge after hold_full is seen high; at that edge shifter <= hold, hold_full <= 0, bit counter <= 0, cycle counter <= 0.
REQ-016 Each bit period SHALL last exactly 16 clk cycles, indexed by a 4-bit cycle counter c = 0..15.
REQ-017 During cycle c of a bit, dout SHALL equal c[2] for a '1' bit (period 8, two rising edges per bit) and c[3] for a '0' bit (period 16, one rising edge per bit).
REQ-018 Every bit SHALL start with dout = 0 (phase restarts per bit), so no extra rising edge occurs at bit boundaries.
REQ-019 At c = 15 the cycle counter SHALL wrap to 0, the shifter SHALL shift left by one, and the bit counter SHALL increment.
REQ-020 At c = 15 of bit DATA_W-1 with hold_full = 1, the block SHALL load the shifter from hold, clear hold_full, and stay in SEND with no gap cycle.
REQ-021 At c = 15 of bit DATA_W-1 with hold_full = 0, the block SHALL go to IDLE, and dout SHALL be 0 from the next cycle.
REQ-022 done SHALL pulse in the cycle after every word's final bit period, including back-to-back words.
REQ-023 bit_start SHALL be high exactly in cycles with c = 0 while in SEND.
REQ-024 In IDLE, dout, bit_start and done SHALL be 0.
REQ-025 busy SHALL equal (state == SEND) || hold_full.
REQ-026 Handshake and hold-to-shifter transfer SHALL never coincide, since the handshake needs hold_full = 0 and the transfer needs hold_full = 1.
REQ-027 Latency SHALL be: handshake at edge E0, first bit's c = 0 cycle begins after edge E0+1 when the block was idle.

Reset
REQ-028 While rst is high at a rising edge, the block SHALL set state = IDLE, hold_full = 0, counters = 0, shifter = 0, dout = 0, bit_start = 0, done = 0.
REQ-029 Reset asserted mid-word SHALL abort transmission and discard any held word, with dout = 0 from the next cycle and no done pulse.
REQ-030 din_ready SHALL be 0 while rst = 1 and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 Single word: send 0xA5 from idle -> 128 cycles of SEND, rising edges per 16-cycle bit window = 2,1,2,1,1,2,1,2, then one done pulse, and busy = 0 with dout = 0 after.
REQ-032 Back-to-back: send 0xFF then immediately 0x00 -> 256 contiguous SEND cycles, 16 rising edges then 8, two done pulses 128 cycles apart, and no idle gap.
REQ-033 Backpressure: hold din_valid = 1 with three words -> first and second accepted, din_ready = 0 until the first word finishes, then the third is accepted on the transfer edge + 1.
REQ-034 Reset mid-word: assert rst at bit 3, c = 7 of 0x3C -> next cycle dout = 0, busy = 0, din_ready = 1 after release, no done pulse.
REQ-035 Timing: handshake at edge E0 from idle -> bit_start high in the cycle after E0+1, and bit_start repeats every 16 cycles, 8 times.
REQ-036 Idle stability: din_valid = 0 for 100 cycles -> dout = 0, busy = 0, din_ready = 1 throughout.

Source files
------------

// File: rtl/fsk_modulator.sv
// Serial FSK modulator: each accepted word is sent MSB first, 16 clocks per bit,
// with a period-8 square wave for '1' bits and a period-16 square wave for '0' bits.
module fsk_modulator #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              busy,
  output logic              bit_start,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   shifter_q, shifter_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]          cyc_q, cyc_d;
  logic                dout_q, dout_d;
  logic                bit_start_q, bit_start_d;
  logic                done_q, done_d;

  assign din_ready = !hold_full_q && !rst;
  assign busy      = (state_q == SEND) || hold_full_q;
  assign dout      = dout_q;
  assign bit_start = bit_start_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shifter_d   = shifter_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_d       = cyc_q;
    done_d      = 1'b0;
    dout_d      = 1'b0;
    bit_start_d = 1'b0;

    // A handshake needs an empty holding register, a transfer needs a full one,
    // so the two updates of hold_full below can never collide.
    if (din_valid && din_ready) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = SEND;
          shifter_d   = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          cyc_d       = '0;
        end
      end
      SEND: begin
        cyc_d = cyc_q + 4'd1;
        if (cyc_q == 4'hF) begin
          if (bit_cnt_q == LAST_BIT) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (hold_full_q) begin
              shifter_d   = hold_q;
              hold_full_d = 1'b0;
            end else begin
              state_d   = IDLE;
              shifter_d = '0;
            end
          end else begin
            shifter_d = shifter_q << 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state;
    // phase restarts at c = 0 of every bit so each bit begins low.
    if (state_d == SEND) begin
      bit_start_d = (cyc_d == 4'd0);
      dout_d      = shifter_d[DATA_W-1] ? cyc_d[2] : cyc_d[3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shifter_q   <= '0;
      bit_cnt_q   <= '0;
      cyc_q       <= '0;
      dout_q      <= 1'b0;
      bit_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shifter_q   <= shifter_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_q       <= cyc_d;
      dout_q      <= dout_d;
      bit_start_q <= bit_start_d;
      done_q      <= done_d;
    end
  end

endmodule
